// File: rtl/bidirectional_port.sv
// Memory-mapped 32-bit GPIO: per-pin direction/enable, 2-flop synchronized and
// tick-debounced inputs, rising-edge interrupts with write-1-to-clear status.
module bidirectional_port #(
  parameter int DEBOUNCE_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        wr,
  input  logic [2:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        irq,
  inout  wire  [31:0] port_io
);

  localparam int CW = $clog2(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] TICK_LAST = CW'(DEBOUNCE_TICKS - 1);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_CONFIG = 3'd1;
  localparam logic [2:0] A_ENABLE = 3'd2;
  localparam logic [2:0] A_IRQ_EN = 3'd3;
  localparam logic [2:0] A_IRQ_ST = 3'd4;

  logic [31:0] data_q, data_d;
  logic [31:0] config_q, config_d;
  logic [31:0] enable_q, enable_d;
  logic [31:0] irq_en_q, irq_en_d;
  logic [31:0] irq_status_q, irq_status_d;
  logic [31:0] sync1_q, sync1_d;
  logic [31:0] sync2_q, sync2_d;
  logic [31:0] sample_q, sample_d;
  logic [31:0] debounced_q, debounced_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;

  logic        tick;
  logic        wr_en;
  logic [31:0] w1c;
  logic [31:0] rise;
  logic [31:0] agree;
  logic [31:0] pin_oe;

  always_comb begin
    data_d       = data_q;
    config_d     = config_q;
    enable_d     = enable_q;
    irq_en_d     = irq_en_q;
    sample_d     = sample_q;
    debounced_d  = debounced_q;
    sync1_d      = port_io;
    sync2_d      = sync1_q;
    tick         = (tick_cnt_q == TICK_LAST);
    tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
    wr_en        = ce & wr;
    w1c          = '0;
    agree        = ~(sync2_q ^ sample_q);

    // A bit only follows the pin once two consecutive tick samples agree.
    if (tick) begin
      sample_d    = sync2_q;
      debounced_d = (debounced_q & ~agree) | (sync2_q & agree);
    end

    if (wr_en) begin
      case (addr)
        A_DATA:   data_d   = data_in;
        A_CONFIG: config_d = data_in;
        A_ENABLE: enable_d = data_in;
        A_IRQ_EN: irq_en_d = data_in;
        A_IRQ_ST: w1c      = data_in;
        default:  ;
      endcase
    end

    // A new edge wins over a clear of the same bit in the same cycle.
    rise         = debounced_d & ~debounced_q & enable_q & config_q & irq_en_q;
    irq_status_d = (irq_status_q & ~w1c) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q       <= '0;
      config_q     <= '0;
      enable_q     <= '0;
      irq_en_q     <= '0;
      irq_status_q <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      sample_q     <= '0;
      debounced_q  <= '0;
      tick_cnt_q   <= '0;
    end else begin
      data_q       <= data_d;
      config_q     <= config_d;
      enable_q     <= enable_d;
      irq_en_q     <= irq_en_d;
      irq_status_q <= irq_status_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sample_q     <= sample_d;
      debounced_q  <= debounced_d;
      tick_cnt_q   <= tick_cnt_d;
    end
  end

  assign pin_oe = enable_q & ~config_q;

  for (genvar i = 0; i < 32; i++) begin : g_pin
    assign port_io[i] = pin_oe[i] ? data_q[i] : 1'bz;
  end

  always_comb begin
    data_out = '0;
    if (ce && !wr) begin
      case (addr)
        A_DATA:   data_out = (enable_q & config_q & debounced_q) | (pin_oe & data_q);
        A_CONFIG: data_out = config_q;
        A_ENABLE: data_out = enable_q;
        A_IRQ_EN: data_out = irq_en_q;
        A_IRQ_ST: data_out = irq_status_q;
        default:  data_out = '0;
      endcase
    end
  end

  assign irq = |(irq_status_q & irq_en_q);

endmodule

// File: tb/tb_bidirectional_port.sv
// Bench for bidirectional_port: directed scenarios plus randomized pin and
// register traffic, all checked against a sample-history reference model.
module tb_bidirectional_port;

  localparam int N = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        wr;
  logic [2:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        irq;
  wire  [31:0] port_io;

  logic [31:0] tb_val;
  logic [31:0] tb_oe;

  // Reference model state
  logic [31:0] m_data, m_cfg, m_en, m_ien, m_ist, m_sample, m_deb;
  int          edge_cnt;
  logic [31:0] hist[$];

  int n_checks = 0;
  int n_pass   = 0;

  bidirectional_port #(.DEBOUNCE_TICKS(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .irq      (irq),
    .port_io  (port_io)
  );

  always #5 clk = ~clk;

  // The bench drives every pin the DUT is supposed to leave floating.
  assign tb_oe = ~(m_en & ~m_cfg);
  for (genvar i = 0; i < 32; i++) begin : g_drv
    assign port_io[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return (m_en & m_cfg & m_deb) | (m_en & ~m_cfg & m_data);
      3'd1:    return m_cfg;
      3'd2:    return m_en;
      3'd3:    return m_ien;
      3'd4:    return m_ist;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_pins();
    return (m_en & ~m_cfg & m_data) | (tb_oe & tb_val);
  endfunction

  task automatic model_reset();
    m_data = '0; m_cfg = '0; m_en = '0; m_ien = '0; m_ist = '0;
    m_sample = '0; m_deb = '0; edge_cnt = 0;
    hist = {32'h0, 32'h0};
  endtask

  // One clock: capture pins/bus before the edge, advance the model at the edge,
  // return at the following falling edge.
  task automatic cycle();
    logic [31:0] pin_pre, d, samp, nd, rise, clr;
    logic        we;
    logic [2:0]  a;
    #1;
    pin_pre = port_io;
    we = ce & wr;
    a  = addr;
    d  = data_in;
    @(posedge clk);
    edge_cnt++;
    hist.push_front(pin_pre);
    nd   = m_deb;
    rise = '0;
    if (edge_cnt % N == 0) begin
      samp = hist[2];
      for (int i = 0; i < 32; i++)
        if (samp[i] == m_sample[i]) nd[i] = samp[i];
      rise = nd & ~m_deb & m_en & m_cfg & m_ien;
      m_sample = samp;
    end
    clr   = (we && a == 3'd4) ? d : 32'h0;
    m_ist = (m_ist & ~clr) | rise;
    m_deb = nd;
    if (we) begin
      case (a)
        3'd0: m_data = d;
        3'd1: m_cfg  = d;
        3'd2: m_en   = d;
        3'd3: m_ien  = d;
        default: ;
      endcase
    end
    while (hist.size() > 2) void'(hist.pop_back());
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] v);
    ce = 1'b1; wr = 1'b1; addr = a; data_in = v;
    cycle();
    ce = 1'b0; wr = 1'b0;
  endtask

  task automatic read_check(input logic [2:0] a, input string tag, output logic [31:0] got);
    ce = 1'b1; wr = 1'b0; addr = a;
    #1;
    got = data_out;
    check(tag, got, model_read(a));
    ce = 1'b0;
    cycle();
  endtask

  task automatic reset_dut();
    ce = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    rst = 1'b1;
    model_reset();
    #1;
    for (int a = 0; a < 8; a++) begin
      ce = 1'b1; addr = 3'(a);
      #1;
      check("rst_reg", data_out, 32'h0);
    end
    ce = 1'b0;
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_pins", port_io, tb_val);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    int lat, first_seen, r;
    bit hit;

    tb_val = '0;
    reset_dut();

    // Reset values through the bus
    for (int a = 0; a < 8; a++) read_check(3'(a), "reset_read", got);

    // Mixed direction: outputs on [7:4], inputs on [3:0]
    write_reg(3'd1, 32'h0000000F);
    write_reg(3'd2, 32'h000000FF);
    write_reg(3'd0, 32'h000000A0);
    check("out_pins", port_io, model_pins());
    check("out_pins_lit", port_io & 32'hFF, 32'h000000A0);
    read_check(3'd0, "data_rd", got);
    check("data_rd_lit", got, 32'h000000A0);
    write_reg(3'd0, 32'h000000AF);
    check("in_pins_hiz", port_io & 32'hFF, 32'h000000A0);
    read_check(3'd0, "data_rd2", got);
    check("data_rd2_lit", got, 32'h000000A0);

    // Debounced rising edge on bit 2 raises the interrupt
    write_reg(3'd3, 32'h4);
    tb_val[3:0] = 4'b0100;
    lat = 1000;
    for (int c = 1; c <= 200; c++) begin
      cycle();
      check("irq_run", {31'h0, irq}, {31'h0, |(m_ist & m_ien)});
      if (irq && lat == 1000) lat = c;
    end
    check("irq_latency", 32'(lat <= 2 * N + 2), 32'h1);
    read_check(3'd4, "ist_set", got);
    check("ist_set_lit", got, 32'h4);
    write_reg(3'd4, 32'h4);
    check("irq_clr", {31'h0, irq}, 32'h0);

    // Three-cycle glitch on bit 0 placed between ticks
    write_reg(3'd3, 32'h5);
    for (int g = 0; g < N && (edge_cnt % N) != 1; g++) cycle();
    tb_val[0] = 1'b1;
    repeat (3) cycle();
    tb_val[0] = 1'b0;
    repeat (3 * N) cycle();
    read_check(3'd0, "glitch_data", got);
    check("glitch_deb0", got & 32'h1, 32'h0);
    read_check(3'd4, "glitch_ist", got);
    check("glitch_ist_lit", got, 32'h0);

    // W1C of bit 2 in the same cycle a new rising edge is recorded
    tb_val[2] = 1'b0;
    repeat (2 * N + 4) cycle();
    tb_val[2] = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 4 * N && !hit; c++) begin
      if (((edge_cnt + 1) % N == 0) && hist[1][2] && m_sample[2] && !m_deb[2]) begin
        write_reg(3'd4, 32'h4);
        hit = 1'b1;
      end else begin
        cycle();
      end
    end
    check("w1c_collide_hit", {31'h0, hit}, 32'h1);
    read_check(3'd4, "w1c_collide", got);
    check("w1c_collide_b2", got & 32'h4, 32'h4);
    write_reg(3'd4, 32'h4);

    // Output bit 5 already high turns into an input: no edge
    tb_val[5] = 1'b1;
    write_reg(3'd3, 32'h24);
    write_reg(3'd1, 32'h2F);
    repeat (3 * N) cycle();
    read_check(3'd4, "dir_swap_ist", got);
    check("dir_swap_b5", got & 32'h20, 32'h0);
    read_check(3'd0, "dir_swap_data", got);

    // Reset in the middle of debouncing a high bit 1
    tb_val[1] = 1'b0;
    repeat (2 * N + 4) cycle();
    tb_val[1] = 1'b1;
    repeat (N + 3) cycle();
    reset_dut();
    write_reg(3'd1, 32'h2);
    write_reg(3'd2, 32'h2);
    first_seen = -1;
    for (int c = 0; c < 3 * N; c++) begin
      if (first_seen < 0) begin
        ce = 1'b1; wr = 1'b0; addr = 3'd0;
        #1;
        if (data_out[1]) first_seen = edge_cnt;
        ce = 1'b0;
      end
      read_check(3'd0, "post_rst_data", got);
    end
    check("post_rst_two_ticks", 32'(first_seen), 32'(2 * N));

    // Disabled outputs float even with DATA all ones
    tb_val = '0;
    write_reg(3'd2, 32'h0);
    write_reg(3'd1, 32'h0);
    write_reg(3'd0, 32'hFFFFFFFF);
    check("disabled_pins", port_io, model_pins());
    check("disabled_pins_lit", port_io, 32'h0);
    read_check(3'd0, "disabled_data", got);
    check("disabled_data_lit", got, 32'h0);

    // Randomized traffic
    write_reg(3'd2, $urandom);
    write_reg(3'd1, $urandom);
    write_reg(3'd3, $urandom);
    write_reg(3'd0, $urandom);
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 15);
      if (r < 3) tb_val = tb_val ^ ($urandom & $urandom & $urandom);
      if (r == 3)      write_reg(3'd4, $urandom);
      else if (r == 4) write_reg(3'($urandom_range(0, 7)), $urandom);
      else             read_check(3'($urandom_range(0, 7)), "rand_rd", got);
      check("rand_irq", {31'h0, irq}, {31'h0, |(m_ist & m_ien)});
      check("rand_pins", port_io, model_pins());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bidirectional_port.md
BIDIRECTIONAL_PORT -- requirements
Module: bidirectional_port

Interface
REQ-001 SHALL have parameter DEBOUNCE_TICKS, default 1000, meaning clock cycles between input sample ticks (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-004 SHALL have port ce  input  1  register access enable from address decoder.
REQ-005 SHALL have port wr  input  1  1 = write access, 0 = read access.
REQ-006 SHALL have port addr  input  3  word register select.
REQ-007 SHALL have port data_in  input  32  write data from CPU.
REQ-008 SHALL have port data_out  output  32  read data to CPU.
REQ-009 SHALL have port irq  output  1  interrupt request, level, active-high.
REQ-010 SHALL have port port_io  inout  32  external pins (buttons, LEDs).

Function
REQ-011 SHALL implement registers: addr 0 DATA, 1 CONFIG (bit=1 input, 0 output), 2 ENABLE (bit=1 pin active), 3 IRQ_EN, 4 IRQ_STATUS; addr 5-7 read 0, writes ignored.
REQ-012 SHALL update the register selected by addr on the rising clk edge when ce=1 and wr=1.
REQ-013 SHALL treat writes to IRQ_STATUS as write-1-to-clear; zero bits leave status unchanged.
REQ-014 SHALL drive port_io[i] = DATA[i] when ENABLE[i]=1 and CONFIG[i]=0, else high-Z.
REQ-015 SHALL pass each port_io bit through a 2-flop synchronizer before any use.
REQ-016 SHALL run a free-running tick counter 0..DEBOUNCE_TICKS-1 that wraps to 0 and asserts a one-cycle sample tick at the wrap.
REQ-017 SHALL, on each tick, capture the synchronized inputs into a sample register and set debounced[i] = sample[i] only when the new and previous samples agree for bit i.
REQ-018 SHALL produce data_out combinationally (zero read latency) when ce=1 and wr=0, and 0 otherwise.
REQ-019 SHALL, on DATA reads, return bit i = debounced[i] if ENABLE[i]=1 and CONFIG[i]=1, DATA[i] if ENABLE[i]=1 and CONFIG[i]=0, 0 if ENABLE[i]=0.
REQ-020 SHALL set IRQ_STATUS[i] on the cycle debounced[i] rises 0->1 while ENABLE[i]=1, CONFIG[i]=1 and IRQ_EN[i]=1.
REQ-021 SHALL give set priority over a same-cycle W1C clear of the same bit.
REQ-022 SHALL keep IRQ_STATUS bits set until cleared, even if IRQ_EN or ENABLE is later deasserted.
REQ-023 SHALL drive irq = OR of (IRQ_STATUS & IRQ_EN), registered-free, combinational from state.
REQ-024 SHALL, on a direction change from output to input, stop driving the pin in the same cycle that CONFIG updates.
REQ-025 SHALL not generate an edge when a bit switches from output to input with debounced already 1.
REQ-026 SHALL recognize a pulse only if it is stable across two consecutive ticks; shorter glitches SHALL be filtered.

Reset
REQ-027 SHALL, on rst=1, asynchronously clear DATA, CONFIG, ENABLE, IRQ_EN, IRQ_STATUS, synchronizer flops, sample, debounced and the tick counter to 0.
REQ-028 SHALL hold all pins high-Z and irq=0 while rst=1 and after reset until software configures the port.
REQ-029 SHALL, when rst asserts mid-debounce, discard partial samples; no edge event SHALL follow reset release until two agreeing post-reset ticks.

Verification
REQ-030 SHALL verify: after reset, write CONFIG=0x0000000F, ENABLE=0x000000FF, DATA=0x000000A0 -> port_io[7:4]=4'hA, port_io[3:0] high-Z, DATA read = 0x000000A0 with inputs 0.
REQ-031 SHALL verify: DEBOUNCE_TICKS=10, IRQ_EN=0x4, drive port_io[3:0]=4'b0100 for 200 cycles -> IRQ_STATUS=0x4, irq=1 within 2 ticks + 2 cycles; write 0x4 to IRQ_STATUS -> irq=0.
REQ-032 SHALL verify: DEBOUNCE_TICKS=10, 3-cycle pulse on port_io[0] between ticks -> debounced[0] stays 0, IRQ_STATUS=0.
REQ-033 SHALL verify: W1C of bit 2 in the same cycle as a new rising edge on bit 2 -> IRQ_STATUS[2]=1 afterwards.
REQ-034 SHALL verify: rst asserted while port_io[1]=1 mid-debounce -> all registers 0, irq=0 immediately; after release, DATA read with bit 1 configured input shows 1 only after two ticks.
REQ-035 SHALL verify: ENABLE=0 with CONFIG=0, DATA=0xFFFFFFFF -> all pins high-Z, DATA read returns 0x00000000.
